// File: rtl/booths_multiplier.sv
// booths_multiplier: sequential radix-2 Booth multiplier for signed operands.
// One recode/add/shift step per clock; WIDTH steps per product, followed by a
// one-cycle done pulse with a registered 2*WIDTH-bit product.
// Optional build macro: BOOTH_ZERO_SKIP_EN -- when defined, a zero operand on
// the accepting edge bypasses the iterative run and produces 0 directly.
module booths_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // A and M carry one extra sign bit so that subtracting the most negative
    // multiplicand cannot overflow the partial-product accumulator.
    logic [WIDTH:0]     r_a;
    logic [WIDTH:0]     r_m;
    logic [WIDTH-1:0]   r_q;
    logic               r_q1;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic               w_accept;
    logic               w_zero;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_a_next;
    logic [WIDTH-1:0]   w_q_next;
    logic               w_q1_next;

    // A new operation is accepted whenever no run is in flight.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_count == CW'(1));

`ifdef BOOTH_ZERO_SKIP_EN
    assign w_zero = (a == '0) || (b == '0);
`else
    assign w_zero = 1'b0;
`endif

    // Booth recode of the {Q[0], Q_-1} pair selects add, subtract or nothing.
    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    // Arithmetic right shift of the concatenated {A, Q, Q_-1} register.
    assign w_a_next  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_next  = {w_sum[0], r_q[WIDTH-1:1]};
    assign w_q1_next = r_q[0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (w_accept) begin
                    w_state_next = w_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture on accept, one Booth step per RUN cycle,
    // product update only on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            if (w_zero) begin
                r_product <= '0;
            end else begin
                r_a     <= '0;
                r_m     <= {a[WIDTH-1], a};
                r_q     <= b;
                r_q1    <= 1'b0;
                r_count <= CW'(WIDTH);
            end
        end else if (r_state == S_RUN) begin
            r_a     <= w_a_next;
            r_q     <= w_q_next;
            r_q1    <= w_q1_next;
            r_count <= r_count - CW'(1);
            if (w_last) begin
                r_product <= {w_a_next[WIDTH-1:0], w_q_next};
            end
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booths_multiplier.sv
// tb_booths_multiplier: randomized self-checking bench for booths_multiplier
// (WIDTH=8). Expected products come from plain signed integer multiplication.
module tb_booths_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [2*W-1:0] prev_exp;

    always #5 clk = ~clk;

    booths_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[2*W-1:0];
    endfunction

    // Number of rising edges after the accepting edge before done is seen.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef BOOTH_ZERO_SKIP_EN
        if (x == '0 || y == '0) return 0;
`endif
        return W;
    endfunction

    // Called at a negedge. Launches one operation and follows it to done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input bit poke, input bit b2b, input string tag);
        logic [2*W-1:0] e;
        int lat;
        int bcnt;
        int el;
        e  = ref_mul(ta, tb_v);
        el = ref_lat(ta, tb_v);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        if (el != 0) check({tag, "/held"}, 32'(product), 32'(prev_exp));
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (poke && lat == 3) begin
                start = 1'b1;
                a = 8'($urandom);
                b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "/latency"}, 32'(lat), 32'(el));
        check({tag, "/busy_cycles"}, 32'(bcnt), 32'(el));
        check({tag, "/busy_in_done"}, 32'(busy), 32'(0));
        check({tag, "/product"}, 32'(product), 32'(e));
        $display("op %s: a=%0d b=%0d product=%04h expect=%04h latency=%0d",
                 tag, $signed(ta), $signed(tb_v), product, e, lat);
        prev_exp = e;
        if (!b2b) begin
            @(negedge clk);
            check({tag, "/done_pulse"}, 32'(done), 32'(0));
            check({tag, "/idle_busy"}, 32'(busy), 32'(0));
            check({tag, "/idle_hold"}, 32'(product), 32'(e));
        end
    endtask

    initial begin
        int seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        prev_exp = '0;
        #2;
        check("reset/busy", 32'(busy), 32'(0));
        check("reset/done", 32'(done), 32'(0));
        check("reset/product", 32'(product), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd3, 8'd5, 1'b0, 1'b0, "3x5");
        run_op(8'h80, 8'h80, 1'b0, 1'b0, "min_x_min");
        run_op(8'h80, 8'h7F, 1'b0, 1'b0, "min_x_max");
        run_op(8'd7, 8'hFF, 1'b1, 1'b0, "7x-1_poke");
        run_op(8'h12, 8'h34, 1'b0, 1'b1, "b2b_first");
        run_op(8'hF0, 8'h0B, 1'b0, 1'b0, "b2b_second");
        run_op(8'd0, 8'd9, 1'b0, 1'b0, "0x9");
        run_op(8'd9, 8'd0, 1'b0, 1'b0, "9x0");
        run_op(8'd100, 8'd77, 1'b0, 1'b0, "pre_reset");

        // Abort a run in its 4th RUN cycle with an asynchronous reset.
        a = 8'd55;
        b = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset/busy", 32'(busy), 32'(0));
        check("midreset/done", 32'(done), 32'(0));
        check("midreset/product", 32'(product), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midreset/no_activity", 32'(seen), 32'(0));
        $display("op midreset: run aborted, activity_after_release=%0d", seen);
        prev_exp = '0;
        run_op(8'hFB, 8'd9, 1'b0, 1'b0, "after_reset");

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 7 == 3) ra = '0;
            run_op(ra, rb, (i % 5 == 1), (i % 4 == 2), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
